// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// ALU operation codes, ALUOp classes and instruction field constants.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  function automatic logic funct_ok(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU control decode: ALUOp class plus R-type funct to a 4-bit ALU code.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl
);

  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_ADD; // FN_ADD and unsupported codes
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath; outputs depend only on
// the state register and the opcode/funct latched in DECODE.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] selectionLines,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] state
);

  state_t     st, st_nxt;
  logic [5:0] op_q, fn_q;
  logic [1:0] alu_op;
  logic       pc_wr, pc_wr_cond, mem_wr, ir_wr, reg_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= S_FETCH;
      op_q <= '0;
      fn_q <= '0;
    end else begin
      st <= st_nxt;
      if (st == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

  always_comb begin
    st_nxt     = S_FETCH;
    alu_op     = ALUOP_ADD;
    pc_wr      = 1'b0;
    pc_wr_cond = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSource   = 2'b00;
    case (st)
      S_FETCH: begin
        MemRead = 1'b1;
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        ALUSrcB = 2'b01;
        st_nxt  = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: st_nxt = S_MEMADR;
          OP_RTYPE:     st_nxt = S_RTYPE_EX;
          OP_BEQ:       st_nxt = S_BEQ_EX;
          OP_J:         st_nxt = S_JUMP;
          OP_ADDI:      st_nxt = S_ADDI_EX;
          default:      st_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        st_nxt  = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        st_nxt  = S_MEMWB;
      end
      S_MEMWB: begin
        reg_wr   = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        IorD   = 1'b1;
      end
      S_RTYPE_EX: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
        // unsupported funct decodes to ADD and skips the register write
        st_nxt  = funct_ok(fn_q) ? S_RTYPE_WB : S_FETCH;
      end
      S_RTYPE_WB: begin
        RegDst = 1'b1;
        reg_wr = 1'b1;
      end
      S_BEQ_EX: begin
        ALUSrcA    = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_wr_cond = 1'b1;
        PCSource   = 2'b01;
      end
      S_JUMP: begin
        pc_wr    = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        st_nxt  = S_ADDI_WB;
      end
      S_ADDI_WB: reg_wr = 1'b1;
      default: st_nxt = S_FETCH;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op  (alu_op),
    .funct   (fn_q),
    .alu_ctl (selectionLines)
  );

  // reset masks the FETCH enables so nothing is written while held
  assign PCWrite     = pc_wr      & ~reset;
  assign PCWriteCond = pc_wr_cond & ~reset;
  assign MemWrite    = mem_wr     & ~reset;
  assign IRWrite     = ir_wr      & ~reset;
  assign RegWrite    = reg_wr     & ~reset;
  assign state       = st;

endmodule
